// File: rtl/dsp_issue_ctrl.sv
// Issue stage for DSP_top: paces requests by mode-dependent II, drains before mode/mac changes,
// returns results at fixed latency. Optional macro DSP_ISSUE_SIGN_EXT_EN formats narrow-mode operands.
module dsp_issue_ctrl #(
  parameter int N       = 32,
  parameter int M       = 32,
  parameter int PIPES   = 2,
  parameter int RES_LAT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic             in_mac,
  input  logic [1:0]       in_shift,
  input  logic [N-1:0]     in_a,
  input  logic [M-1:0]     in_b,
  input  logic [N+M-1:0]   in_c,
  output logic             start,
  output logic [1:0]       mode,
  output logic             mac,
  output logic [1:0]       shift_amount,
  output logic             shift_dir,
  output logic [N-1:0]     aa,
  output logic [M-1:0]     bb,
  output logic [N+M-1:0]   cc,
  input  logic [N+M-1:0]   dsp_out,
  output logic             res_valid,
  output logic [N+M-1:0]   res_data,
  output logic [1:0]       res_mode,
  output logic             busy,
  output logic             err
);

  localparam int N2    = N / 2;
  localparam int DEPTH = 4 + RES_LAT;
  localparam int PW    = $clog2(DEPTH);
  localparam int IW    = $clog2(RES_LAT + 2);

  if (RES_LAT < 1 || PIPES < 1 || (N % 2) != 0 || (M % 2) != 0) begin : g_bad_params
    $error("dsp_issue_ctrl: illegal parameter combination");
  end

  logic [1:0]             hold_cnt;
  logic [IW-1:0]          inflight;
  logic [1:0]             last_mode;
  logic                   last_mac;
  logic [DEPTH-1:0]       vpipe;
  logic [DEPTH-1:0][1:0]  mpipe;
  logic                   drain;
  logic                   accept;
  logic                   legal;
  logic [1:0]             ii_m1;
  logic [PW-1:0]          ins_idx;
  logic [N-1:0]           a_fmt;
  logic [M-1:0]           b_fmt;

  assign shift_dir = 1'b1;
  assign legal     = (in_mode != 2'd3);

  // The op whose start is high this cycle is not yet in inflight, so it must also block a switch.
  assign drain    = in_valid && ((inflight != '0) || start) &&
                    ((in_mode != last_mode) || (in_mac != last_mac));
  assign in_ready = (hold_cnt == '0) && !drain && !rst;
  assign accept   = in_valid && in_ready;
  assign busy     = (inflight != '0) || (hold_cnt != '0);

  always_comb begin
    ii_m1 = 2'd0;
    case (in_mode)
      2'd1:    ii_m1 = 2'd1;
      2'd2:    ii_m1 = 2'd3;
      default: ii_m1 = 2'd0;
    endcase
  end

  // Result slot is LAT-1 stages up the shift pipe, so it reaches stage 0 LAT edges after acceptance.
  assign ins_idx = PW'(ii_m1) + PW'(RES_LAT);

  always_comb begin
    a_fmt = in_a;
    b_fmt = in_b;
`ifdef DSP_ISSUE_SIGN_EXT_EN
    if (in_mode == 2'd0 || in_mode == 2'd1) a_fmt[N-1:N2+1] = {(N-N2-1){in_a[N2]}};
    if (in_mode == 2'd0)                    b_fmt[M-1:N2+1] = {(M-N2-1){in_b[N2]}};
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      start        <= 1'b0;
      mode         <= '0;
      mac          <= 1'b0;
      shift_amount <= '0;
      aa           <= '0;
      bb           <= '0;
      cc           <= '0;
      hold_cnt     <= '0;
      last_mode    <= '0;
      last_mac     <= 1'b0;
      err          <= 1'b0;
    end else begin
      start <= 1'b0;
      if (hold_cnt != '0) hold_cnt <= hold_cnt - 2'd1;
      if (accept) begin
        if (legal) begin
          start        <= 1'b1;
          mode         <= in_mode;
          mac          <= in_mac;
          shift_amount <= in_shift;
          aa           <= a_fmt;
          bb           <= b_fmt;
          cc           <= in_c;
          hold_cnt     <= ii_m1;
          last_mode    <= in_mode;
          last_mac     <= in_mac;
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vpipe     <= '0;
      mpipe     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_mode  <= '0;
      inflight  <= '0;
    end else begin
      vpipe <= {1'b0, vpipe[DEPTH-1:1]};
      mpipe <= {2'b00, mpipe[DEPTH-1:1]};
      if (accept && legal) begin
        vpipe[ins_idx] <= 1'b1;
        mpipe[ins_idx] <= in_mode;
      end
      res_valid <= vpipe[0];
      if (vpipe[0]) begin
        res_data <= dsp_out;
        res_mode <= mpipe[0];
      end
      if (start && !res_valid)      inflight <= inflight + IW'(1);
      else if (!start && res_valid) inflight <= inflight - IW'(1);
    end
  end

endmodule

// File: tb/tb_dsp_issue_ctrl.sv
// Bench for dsp_issue_ctrl: directed vector table plus randomized traffic against an op-list model.
module tb_dsp_issue_ctrl;
  localparam int N       = 32;
  localparam int M       = 32;
  localparam int W       = N + M;
  localparam int RES_LAT = 3;
  localparam int N2      = N / 2;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, in_mac, start, mac, shift_dir, res_valid, busy, err;
  logic [1:0] in_mode, in_shift, mode, shift_amount, res_mode;
  logic [N-1:0] in_a, aa;
  logic [M-1:0] in_b, bb;
  logic [W-1:0] in_c, cc, dsp_out, res_data;

  always #5 clk = ~clk;

  dsp_issue_ctrl #(.N(N), .M(M), .PIPES(2), .RES_LAT(RES_LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_mac(in_mac), .in_shift(in_shift), .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .start(start), .mode(mode), .mac(mac), .shift_amount(shift_amount), .shift_dir(shift_dir),
    .aa(aa), .bb(bb), .cc(cc), .dsp_out(dsp_out), .res_valid(res_valid), .res_data(res_data),
    .res_mode(res_mode), .busy(busy), .err(err)
  );

  typedef struct { int k; logic [1:0] md; } op_t;
  typedef struct {
    logic r; logic v; logic [1:0] md; logic [N-1:0] a; logic [M-1:0] b;
    logic er; logic es; logic ev;
  } vec_t;

  op_t          ops[$];
  vec_t         tbl[$];
  logic [W-1:0] dsp_hist [int];
  int unsigned  nvec = 0;
  int unsigned  nerr = 0;
  int           cyc = 0;
  logic         chk_en = 1'b0;
  logic         last_acc = 1'b0;

  int           last_k = -100;
  int           last_ii = 1;
  logic [1:0]   lmode = '0, lshift = '0;
  logic         lmac = 1'b0, err_m = 1'b0;
  logic [N-1:0] la = '0;
  logic [M-1:0] lb = '0;
  logic [W-1:0] lc = '0;

  function automatic int ii_of(logic [1:0] md);
    return (md == 2'd1) ? 2 : (md == 2'd2) ? 4 : 1;
  endfunction

  function automatic int lat_of(logic [1:0] md);
    return ii_of(md) + RES_LAT;
  endfunction

  function automatic logic [N-1:0] fmt_a(logic [1:0] md, logic [N-1:0] a);
    logic [N-1:0] r;
    r = a;
`ifdef DSP_ISSUE_SIGN_EXT_EN
    if (md == 2'd0 || md == 2'd1) r = a[N2] ? (a | ~((N'(1) << (N2 + 1)) - N'(1))) : (a & ((N'(1) << (N2 + 1)) - N'(1)));
`endif
    return r;
  endfunction

  function automatic logic [M-1:0] fmt_b(logic [1:0] md, logic [M-1:0] b);
    logic [M-1:0] r;
    r = b;
`ifdef DSP_ISSUE_SIGN_EXT_EN
    if (md == 2'd0) r = b[N2] ? (b | ~((M'(1) << (N2 + 1)) - M'(1))) : (b & ((M'(1) << (N2 + 1)) - M'(1)));
`endif
    return r;
  endfunction

  function automatic void chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endfunction

  function automatic void add(logic r, logic v, logic [1:0] md, logic [N-1:0] a, logic [M-1:0] b,
                              logic er, logic es, logic ev);
    vec_t t;
    t.r = r; t.v = v; t.md = md; t.a = a; t.b = b; t.er = er; t.es = es; t.ev = ev;
    tbl.push_back(t);
  endfunction

  task automatic step(input logic r, input logic v, input logic [1:0] md, input logic mc,
                      input logic [1:0] sh, input logic [N-1:0] a, input logic [M-1:0] b,
                      input logic [W-1:0] c, output logic o_rdy, output logic o_st, output logic o_rv);
    logic e_st, e_rv, e_hold, pend, e_rdy, acc;
    logic [1:0] e_rmode;
    int nfly;
    rst = r; in_valid = v; in_mode = md; in_mac = mc; in_shift = sh;
    in_a = a; in_b = b; in_c = c;
    dsp_out = W'({$urandom, $urandom});
    dsp_hist[cyc] = dsp_out;
    while (ops.size() > 0 && ops[0].k + 1 + lat_of(ops[0].md) < cyc) void'(ops.pop_front());
    e_st = 1'b0; e_rv = 1'b0; pend = 1'b0; e_rmode = '0; nfly = 0;
    foreach (ops[i]) begin
      if (ops[i].k == cyc - 1) e_st = 1'b1;
      if (ops[i].k + 1 + lat_of(ops[i].md) == cyc) begin e_rv = 1'b1; e_rmode = ops[i].md; end
      if (ops[i].k + 1 < cyc && cyc <= ops[i].k + 1 + lat_of(ops[i].md)) nfly++;
      if (ops[i].k < cyc && cyc <= ops[i].k + 1 + lat_of(ops[i].md)) pend = 1'b1;
    end
    e_hold = (cyc > last_k) && (cyc < last_k + last_ii);
    e_rdy  = !e_hold && !r && !(v && pend && (md != lmode || mc != lmac));
    @(negedge clk);
    if (chk_en) begin
      chk("in_ready", W'(in_ready), W'(e_rdy));
      chk("start", W'(start), W'(e_st));
      chk("res_valid", W'(res_valid), W'(e_rv));
      chk("busy", W'(busy), W'((nfly != 0) || e_hold));
      chk("err", W'(err), W'(err_m));
      chk("mode", W'(mode), W'(lmode));
      chk("mac", W'(mac), W'(lmac));
      chk("shift_amount", W'(shift_amount), W'(lshift));
      chk("shift_dir", W'(shift_dir), W'(1'b1));
      chk("aa", W'(aa), W'(la));
      chk("bb", W'(bb), W'(lb));
      chk("cc", cc, lc);
      if (e_rv) begin
        chk("res_data", res_data, dsp_hist[cyc-1]);
        chk("res_mode", W'(res_mode), W'(e_rmode));
      end
    end
    o_rdy = in_ready; o_st = start; o_rv = res_valid;
    acc = v && e_rdy;
    @(posedge clk); #1;
    if (r) begin
      ops.delete();
      last_k = -100; last_ii = 1; lmode = '0; lmac = 1'b0; lshift = '0;
      la = '0; lb = '0; lc = '0; err_m = 1'b0;
    end else if (acc) begin
      if (md == 2'd3) err_m = 1'b1;
      else begin
        ops.push_back('{k: cyc, md: md});
        last_k = cyc; last_ii = ii_of(md); lmode = md; lmac = mc; lshift = sh;
        la = fmt_a(md, a); lb = fmt_b(md, b); lc = c;
      end
    end
    last_acc = acc;
    cyc++;
  endtask

  initial begin
    logic o_rdy, o_st, o_rv;
    logic pv, pmac;
    logic [1:0] pmd, psh;
    logic [N-1:0] pa;
    logic [M-1:0] pb;
    logic [W-1:0] pc;
    logic [N-1:0] exp_sa;
    logic [M-1:0] exp_sb;

    add(1, 0, 0, '0, '0, 0, 0, 0);
    add(1, 0, 0, '0, '0, 0, 0, 0);
    // Mode 0 stream of 8 back-to-back requests, results 4 cycles after each start.
    add(0, 1, 0, N'(1), M'(1), 1, 0, 0);
    for (int i = 1; i <= 4; i++) add(0, 1, 0, N'(i + 1), M'(i + 1), 1, 1, 0);
    for (int i = 5; i <= 7; i++) add(0, 1, 0, N'(i + 1), M'(i + 1), 1, 1, 1);
    add(0, 0, 0, '0, '0, 1, 1, 1);
    for (int i = 9; i <= 12; i++) add(0, 0, 0, '0, '0, 1, 0, 1);
    add(0, 0, 0, '0, '0, 1, 0, 0);
    // Mode 1 with in_valid held: ready toggles, starts two apart.
    for (int i = 0; i <= 4; i++) add(0, 1, 1, N'(5), M'(7), (i % 2) == 0, (i % 2) == 1, 0);
    add(0, 0, 1, N'(5), M'(7), 0, 1, 0);
    for (int i = 6; i <= 11; i++) add(0, 0, 0, '0, '0, 1, 0, (i % 2) == 0);
    // Mode 0 in flight, then a mode 2 request must wait for the drain.
    add(0, 1, 0, N'(9), M'(3), 1, 0, 0);
    add(0, 1, 0, N'(10), M'(4), 1, 1, 0);
    add(0, 1, 2, N'(11), M'(5), 0, 1, 0);
    add(0, 1, 2, N'(11), M'(5), 0, 0, 0);
    add(0, 1, 2, N'(11), M'(5), 0, 0, 0);
    add(0, 1, 2, N'(11), M'(5), 0, 0, 1);
    add(0, 1, 2, N'(11), M'(5), 0, 0, 1);
    add(0, 1, 2, N'(11), M'(5), 1, 0, 0);
    add(0, 0, 0, '0, '0, 0, 1, 0);
    add(0, 0, 0, '0, '0, 0, 0, 0);
    add(0, 0, 0, '0, '0, 0, 0, 0);
    for (int i = 11; i <= 14; i++) add(0, 0, 0, '0, '0, 1, 0, 0);
    add(0, 0, 0, '0, '0, 1, 0, 1);
    add(0, 0, 0, '0, '0, 1, 0, 0);
    // Illegal mode: accepted without start, err sticky until reset.
    add(0, 1, 3, N'(1), M'(1), 1, 0, 0);
    add(0, 0, 0, '0, '0, 1, 0, 0);
    add(0, 1, 0, N'(2), M'(2), 1, 0, 0);
    add(0, 0, 0, '0, '0, 1, 1, 0);
    for (int i = 4; i <= 6; i++) add(0, 0, 0, '0, '0, 1, 0, 0);
    add(0, 0, 0, '0, '0, 1, 0, 1);
    add(1, 0, 0, '0, '0, 0, 0, 0);
    // Reset one cycle after a mode 2 start drops the op.
    add(0, 1, 2, N'(3), M'(3), 1, 0, 0);
    add(0, 0, 0, '0, '0, 0, 1, 0);
    add(1, 0, 0, '0, '0, 0, 0, 0);
    for (int i = 3; i <= 10; i++) add(0, 0, 0, '0, '0, 1, 0, 0);

    rst = 1'b1; in_valid = 1'b0; in_mode = '0; in_mac = 1'b0; in_shift = '0;
    in_a = '0; in_b = '0; in_c = '0; dsp_out = '0;
    @(posedge clk); #1;
    step(1, 0, 0, 0, 0, '0, '0, '0, o_rdy, o_st, o_rv);
    chk_en = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].v, tbl[i].md, 1'b0, 2'd1, tbl[i].a, tbl[i].b, {tbl[i].a, tbl[i].b},
           o_rdy, o_st, o_rv);
      chk("tbl_ready", W'(o_rdy), W'(tbl[i].er));
      chk("tbl_start", W'(o_st), W'(tbl[i].es));
      chk("tbl_res_valid", W'(o_rv), W'(tbl[i].ev));
    end

`ifdef DSP_ISSUE_SIGN_EXT_EN
    exp_sa = 32'hFFFF_8000; exp_sb = 32'hFFFF_8000;
`else
    exp_sa = 32'h0001_8000; exp_sb = 32'h0001_8000;
`endif
    step(0, 1, 0, 0, 2'd0, 32'h0001_8000, 32'h0001_8000, '0, o_rdy, o_st, o_rv);
    chk("sx_aa", W'(aa), W'(exp_sa));
    chk("sx_bb", W'(bb), W'(exp_sb));
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, '0, '0, '0, o_rdy, o_st, o_rv);

    pv = 1'b0; pmd = '0; pmac = 1'b0; psh = '0; pa = '0; pb = '0; pc = '0;
    for (int i = 0; i < 1500; i++) begin
      if (!pv && $urandom_range(0, 3) != 0) begin
        pv = 1'b1;
        if ($urandom_range(0, 19) == 0) pmd = 2'd3;
        else if ($urandom_range(0, 3) == 0 || pmd == 2'd3) pmd = 2'($urandom_range(0, 2));
        if ($urandom_range(0, 9) == 0) pmac = ~pmac;
        psh = 2'($urandom_range(0, 3));
        pa = N'($urandom); pb = M'($urandom); pc = W'({$urandom, $urandom});
      end
      step(($urandom_range(0, 299) == 0), pv, pmd, pmac, psh, pa, pb, pc, o_rdy, o_st, o_rv);
      if (last_acc) pv = 1'b0;
    end
    for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 0, '0, '0, '0, o_rdy, o_st, o_rv);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
